// File: rtl/blit_pkg.sv
// Shared blitter memory-scheduler types: phase indices, FSM states and width codes.
// Pure definitions, no latency; no flow control of its own.
// The first_en helper returns the lowest enabled phase, or 0 when none is enabled.
package blit_pkg;

    localparam int NUM_PH = 6;

    localparam logic [2:0] PH_SRCD  = 3'd0;
    localparam logic [2:0] PH_SRCZ  = 3'd1;
    localparam logic [2:0] PH_DSTD  = 3'd2;
    localparam logic [2:0] PH_DSTZ  = 3'd3;
    localparam logic [2:0] PH_DSTDW = 3'd4;
    localparam logic [2:0] PH_DSTZW = 3'd5;

    localparam logic [3:0] WID_NONE = 4'd0;
    localparam logic [3:0] WID_8    = 4'd3;
    localparam logic [3:0] WID_16   = 4'd4;
    localparam logic [3:0] WID_32   = 4'd5;
    localparam logic [3:0] WID_64   = 4'd6;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETUP   = 3'd1,
        ST_CYC     = 3'd2,
        ST_STOPPED = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [2:0] first_en(input logic [NUM_PH-1:0] en);
        logic [2:0] r;
        r = PH_SRCD;
        for (int i = NUM_PH - 1; i >= 0; i--) begin
            if (en[i]) r = 3'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/blit_phase_pick.sv
// Next-enabled-phase priority picker: lowest enabled phase above cur_i, else wrap to lowest.
// Purely combinational, zero latency.
// No backpressure; wrap_o=1 means the phrase is complete.
module blit_phase_pick
    import blit_pkg::*;
(
    input  logic [NUM_PH-1:0] en_i,
    input  logic [2:0]        cur_i,
    output logic [2:0]        nxt_o,
    output logic              wrap_o
);

    always_comb begin
        nxt_o  = first_en(en_i);
        wrap_o = 1'b1;
        // Descending scan so the lowest qualifying index wins.
        for (int i = NUM_PH - 1; i >= 0; i--) begin
            if (en_i[i] && (i > int'(cur_i))) begin
                nxt_o  = 3'(i);
                wrap_o = 1'b0;
            end
        end
    end

endmodule

// File: rtl/blit_mem_sched.sv
// Blitter memory-cycle scheduler: walks enabled phases per phrase onto the system bus.
// cmd_go to first mreq is 2 clocks; each bus cycle takes at least 2 clocks (SETUP + CYC).
// Holds mreq/address/width/read stable until ack; BLIT_COLLISION_STOP_EN adds collision stop.
module blit_mem_sched
    import blit_pkg::*;
#(
    parameter int ADDR_W = 24,
    parameter int CNT_W  = 16
) (
    input  logic              sys_clk,
    input  logic              xreset_n,
    input  logic              cmd_go,
    input  logic [CNT_W-1:0]  inner_cnt,
    input  logic [5:0]        phase_en,
    input  logic [ADDR_W-1:0] address,
    input  logic [3:0]        phase_width,
    input  logic              ack,
    input  logic              blit_back,
    input  logic              stop_req,
    input  logic              resume,
    input  logic              abort,
    output logic [1:0]        blit_breq,
    output logic              bus_oe,
    output logic              mreq_out,
    output logic [ADDR_W-1:0] blit_addr_out,
    output logic [3:0]        width_out,
    output logic              read_out,
    output logic [2:0]        phase,
    output logic              phase_adv,
    output logic              busy,
    output logic              stopped,
    output logic [CNT_W-1:0]  inner_rem,
    output logic              blit_int
);

    state_t             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic [5:0]         en_q, en_d;
    logic [CNT_W-1:0]   rem_q, rem_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [3:0]         width_q, width_d;
    logic               read_q, read_d;

    logic [2:0]         pick_nxt;
    logic               pick_wrap;
    logic [CNT_W-1:0]   rem_dec;
    state_t             adv_state;
    logic [2:0]         adv_phase;
    logic [CNT_W-1:0]   adv_rem;
    logic               stop_hit;

    blit_phase_pick u_pick (
        .en_i   (en_q),
        .cur_i  (phase_q),
        .nxt_o  (pick_nxt),
        .wrap_o (pick_wrap)
    );

`ifdef BLIT_COLLISION_STOP_EN
    assign stop_hit = stop_req && ((phase_q == PH_DSTDW) || (phase_q == PH_DSTZW));
    assign stopped  = (state_q == ST_STOPPED);
`else
    logic unused_stop_ins;
    assign unused_stop_ins = &{1'b0, stop_req, resume, abort};
    assign stop_hit = 1'b0;
    assign stopped  = 1'b0;
`endif

    // Phase advance shared by the ack path and the resume-from-stop path.
    always_comb begin
        rem_dec   = (rem_q == '0) ? '0 : rem_q - 1'b1;
        adv_phase = pick_nxt;
        adv_rem   = rem_q;
        adv_state = ST_SETUP;
        if (pick_wrap) begin
            adv_rem = rem_dec;
            if (rem_dec == '0) adv_state = ST_DONE;
        end
    end

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        en_d    = en_q;
        rem_d   = rem_q;
        addr_d  = addr_q;
        width_d = width_q;
        read_d  = read_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_go) begin
                    en_d  = phase_en;
                    rem_d = inner_cnt;
                    if ((inner_cnt == '0) || (phase_en == '0)) begin
                        state_d = ST_DONE;
                    end else begin
                        phase_d = first_en(phase_en);
                        state_d = ST_SETUP;
                    end
                end
            end
            ST_SETUP: begin
                addr_d  = address;
                width_d = phase_width;
                read_d  = (phase_q < PH_DSTDW);
                state_d = ST_CYC;
            end
            ST_CYC: begin
                if (ack) begin
                    if (stop_hit) begin
                        state_d = ST_STOPPED;
                    end else begin
                        state_d = adv_state;
                        phase_d = adv_phase;
                        rem_d   = adv_rem;
                    end
                end
            end
            ST_STOPPED: begin
`ifdef BLIT_COLLISION_STOP_EN
                if (abort) begin
                    state_d = ST_DONE;
                end else if (resume) begin
                    state_d = adv_state;
                    phase_d = adv_phase;
                    rem_d   = adv_rem;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge xreset_n) begin
        if (!xreset_n) begin
            state_q <= ST_IDLE;
            phase_q <= PH_SRCD;
            en_q    <= '0;
            rem_q   <= '0;
            addr_q  <= '0;
            width_q <= WID_NONE;
            read_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            rem_q   <= rem_d;
            addr_q  <= addr_d;
            width_q <= width_d;
            read_q  <= read_d;
        end
    end

    // Bus-facing controls decode straight from state so reset removes them at once.
    assign mreq_out      = (state_q == ST_CYC);
    assign bus_oe        = mreq_out;
    assign blit_breq     = {mreq_out & blit_back, mreq_out};
    assign phase_adv     = mreq_out & ack;
    assign busy          = (state_q != ST_IDLE);
    assign blit_int      = (state_q == ST_DONE);
    assign blit_addr_out = addr_q;
    assign width_out     = width_q;
    assign read_out      = read_q;
    assign phase         = phase_q;
    assign inner_rem     = rem_q;

endmodule

// File: tb/tb_blit_mem_sched.sv
// Directed bench for blit_mem_sched with a queue of expected bus cycles checked per mreq cycle.
// Address/width inputs are derived from the DUT phase and the count of phase_adv pulses seen.
module tb_blit_mem_sched;

    localparam int ADDR_W = 24;
    localparam int CNT_W  = 16;

    logic              sys_clk = 1'b0;
    logic              xreset_n = 1'b0;
    logic              cmd_go = 1'b0;
    logic [CNT_W-1:0]  inner_cnt = '0;
    logic [5:0]        phase_en = '0;
    logic [ADDR_W-1:0] address;
    logic [3:0]        phase_width;
    logic              ack = 1'b0;
    logic              blit_back = 1'b0;
    logic              stop_req = 1'b0;
    logic              resume = 1'b0;
    logic              abort = 1'b0;
    logic [1:0]        blit_breq;
    logic              bus_oe, mreq_out, read_out, phase_adv, busy, stopped, blit_int;
    logic [ADDR_W-1:0] blit_addr_out;
    logic [3:0]        width_out;
    logic [2:0]        phase;
    logic [CNT_W-1:0]  inner_rem;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [3:0]        width;
        logic              rd;
        logic [CNT_W-1:0]  rem;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   adv_cnt = 0;
    int   exp_k = 0;
    int   ack_dly = 0;
    int   wcnt = 0;
    int   mreq_cyc = 0;

    always #5 sys_clk = ~sys_clk;

    assign address     = {phase, 5'd0, 16'(adv_cnt)};
    assign phase_width = {1'b0, phase} + 4'd1;

    blit_mem_sched #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .sys_clk(sys_clk), .xreset_n(xreset_n), .cmd_go(cmd_go), .inner_cnt(inner_cnt),
        .phase_en(phase_en), .address(address), .phase_width(phase_width), .ack(ack),
        .blit_back(blit_back), .stop_req(stop_req), .resume(resume), .abort(abort),
        .blit_breq(blit_breq), .bus_oe(bus_oe), .mreq_out(mreq_out),
        .blit_addr_out(blit_addr_out), .width_out(width_out), .read_out(read_out),
        .phase(phase), .phase_adv(phase_adv), .busy(busy), .stopped(stopped),
        .inner_rem(inner_rem), .blit_int(blit_int)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_phrases(input int cnt, input logic [5:0] en, input int nphr);
        exp_t e;
        for (int j = 0; j < nphr; j++) begin
            for (int p = 0; p < 6; p++) begin
                if (en[p]) begin
                    e.addr  = {3'(p), 5'd0, 16'(exp_k)};
                    e.width = 4'(p + 1);
                    e.rd    = (p < 4);
                    e.rem   = CNT_W'(cnt - j);
                    q.push_back(e);
                    exp_k++;
                end
            end
        end
    endtask

    task automatic go(input int cnt, input logic [5:0] en);
        @(negedge sys_clk);
        inner_cnt = CNT_W'(cnt);
        phase_en  = en;
        cmd_go    = 1'b1;
        @(negedge sys_clk);
        cmd_go    = 1'b0;
    endtask

    task automatic wait_int(input string tag, input int bound, output int n);
        n = 0;
        while (blit_int !== 1'b1 && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_int"}, blit_int, 1);
        chk({tag, "_busy_at_int"}, busy, 1);
        @(negedge sys_clk);
        chk({tag, "_int_one_cycle"}, blit_int, 0);
        chk({tag, "_busy_falls"}, busy, 0);
    endtask

    task automatic wait_stopped(input string tag, input int bound);
        int n = 0;
        while (stopped !== 1'b1 && n < bound) begin
            @(negedge sys_clk);
            n++;
        end
        chk({tag, "_stopped"}, stopped, 1);
    endtask

    // Ack responder: asserts ack after ack_dly waiting cycles of mreq.
    always @(posedge sys_clk) begin
        #1;
        if (!xreset_n || !mreq_out) begin
            ack  = 1'b0;
            wcnt = 0;
        end else if (wcnt >= ack_dly) begin
            ack = 1'b1;
        end else begin
            ack = 1'b0;
            wcnt++;
        end
    end

    // Bus monitor: every mreq cycle must match the head of the expected queue.
    always @(negedge sys_clk) begin
        if (xreset_n) begin
            chk("phase_adv", phase_adv, mreq_out & ack);
            if (mreq_out) begin
                mreq_cyc++;
                if (q.size() == 0) begin
                    chk("unexpected_mreq", mreq_out, 0);
                end else begin
                    chk("bus_addr", blit_addr_out, q[0].addr);
                    chk("bus_width", width_out, q[0].width);
                    chk("bus_read", read_out, q[0].rd);
                    chk("bus_rem", inner_rem, q[0].rem);
                    chk("bus_breq", blit_breq, {blit_back, 1'b1});
                    chk("bus_oe", bus_oe, 1);
                    if (ack) void'(q.pop_front());
                end
            end else begin
                chk("breq_idle", blit_breq, 0);
            end
`ifndef BLIT_COLLISION_STOP_EN
            chk("stopped_tied", stopped, 0);
`endif
            if (phase_adv) adv_cnt++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int adv0, cyc0;
        // Reset state
        #7;
        chk("rst_mreq", mreq_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_breq", blit_breq, 0);
        chk("rst_rem", inner_rem, 0);
        chk("rst_addr", blit_addr_out, 0);
        chk("rst_int", blit_int, 0);
        @(negedge sys_clk);
        xreset_n = 1'b1;

        // Two-phase phrases, three times
        ack_dly = 1;
        adv0 = adv_cnt;
        push_phrases(3, 6'b010001, 3);
        go(3, 6'b010001);
        chk("t1_setup_no_mreq", mreq_out, 0);
        chk("t1_setup_busy", busy, 1);
        chk("t1_rem_loaded", inner_rem, 3);
        @(negedge sys_clk);
        chk("t1_first_mreq", mreq_out, 1);
        wait_int("t1", 200, n);
        chk("t1_adv_pulses", adv_cnt - adv0, 6);
        chk("t1_queue_empty", q.size(), 0);
        chk("t1_rem_end", inner_rem, 0);

        // Zero count and empty enable go straight to DONE
        go(0, 6'b000001);
        wait_int("t2a", 5, n);
        chk("t2a_latency", n, 0);
        go(2, 6'b000000);
        wait_int("t2b", 5, n);
        chk("t2b_latency", n, 0);
        chk("t2_queue_empty", q.size(), 0);

        // Slow ack with hog request; stray cmd_go mid-blit
        ack_dly   = 5;
        blit_back = 1'b1;
        cyc0 = mreq_cyc;
        push_phrases(1, 6'b000101, 1);
        go(1, 6'b000101);
        repeat (3) @(negedge sys_clk);
        go(7, 6'b111111);
        wait_int("t3", 200, n);
        chk("t3_mreq_cycles", mreq_cyc - cyc0, 12);
        chk("t3_queue_empty", q.size(), 0);
        chk("t3_rem_end", inner_rem, 0);
        blit_back = 1'b0;

        // Asynchronous reset during a bus cycle
        ack_dly = 20;
        push_phrases(2, 6'b000001, 1);
        go(2, 6'b000001);
        @(negedge sys_clk);
        chk("t4_in_cyc", mreq_out, 1);
        #2 xreset_n = 1'b0;
        #1;
        chk("t4_mreq_drop", mreq_out, 0);
        chk("t4_breq_drop", blit_breq, 0);
        chk("t4_busy_drop", busy, 0);
        chk("t4_rem_clear", inner_rem, 0);
        @(negedge sys_clk);
        q.delete();
        adv_cnt = 0;
        exp_k   = 0;
        #2 xreset_n = 1'b1;

        // New blit accepted after reset: single write phase
        ack_dly = 0;
        push_phrases(1, 6'b100000, 1);
        go(1, 6'b100000);
        wait_int("t5", 50, n);
        chk("t5_queue_empty", q.size(), 0);

        // Collision stop
        stop_req = 1'b1;
`ifdef BLIT_COLLISION_STOP_EN
        push_phrases(2, 6'b010000, 2);
        go(2, 6'b010000);
        wait_stopped("t6r", 20);
        chk("t6r_breq", blit_breq, 0);
        chk("t6r_mreq", mreq_out, 0);
        chk("t6r_busy", busy, 1);
        chk("t6r_rem", inner_rem, 2);
        chk("t6r_pending", q.size(), 1);
        stop_req = 1'b0;
        resume   = 1'b1;
        @(negedge sys_clk);
        resume   = 1'b0;
        wait_int("t6r", 50, n);
        chk("t6r_queue_empty", q.size(), 0);
        chk("t6r_rem_end", inner_rem, 0);

        stop_req = 1'b1;
        push_phrases(2, 6'b010000, 1);
        go(2, 6'b010000);
        wait_stopped("t6a", 20);
        chk("t6a_mreq", mreq_out, 0);
        abort  = 1'b1;
        resume = 1'b1;
        @(negedge sys_clk);
        abort  = 1'b0;
        resume = 1'b0;
        chk("t6a_int", blit_int, 1);
        chk("t6a_rem_kept", inner_rem, 2);
        chk("t6a_queue_empty", q.size(), 0);
        @(negedge sys_clk);
        chk("t6a_busy_falls", busy, 0);
        chk("t6a_stopped_clear", stopped, 0);
        stop_req = 1'b0;
`else
        push_phrases(2, 6'b010000, 2);
        go(2, 6'b010000);
        repeat (2) @(negedge sys_clk);
        resume = 1'b1;
        abort  = 1'b1;
        @(negedge sys_clk);
        resume = 1'b0;
        abort  = 1'b0;
        wait_int("t6", 50, n);
        chk("t6_queue_empty", q.size(), 0);
        chk("t6_rem_end", inner_rem, 0);
        stop_req = 1'b0;
`endif

        repeat (2) @(negedge sys_clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/blit_mem_sched.md
Name: blit_mem_sched

Overview:
- Sequences the blitter's per-phrase memory cycles onto the shared system bus.
- Per phrase, it walks the enabled phases in fixed order: source data read, source Z read, destination data read, destination Z read, destination data write, destination Z write.
- For each phase it requests the bus, drives address/width/read/mreq until ack, and steps the address unit. It raises the completion interrupt when the inner count is exhausted.

Parameters:
- ADDR_W, 24, bus address width
- CNT_W, 16, inner (phrase) counter width

Ports:
- sys_clk  in  1  system clock
- xreset_n  in  1  asynchronous active-low reset
- cmd_go  in  1  one-cycle start pulse from command register load
- inner_cnt  in  CNT_W  phrase count, sampled at cmd_go
- phase_en  in  6  phase enables, sampled at cmd_go: [0] srcdread, [1] srczread, [2] dstdread, [3] dstzread, [4] dstdwrite, [5] dstzwrite
- address  in  ADDR_W  address from address unit for current phase
- phase_width  in  4  transfer width code for current phase
- ack  in  1  bus cycle accepted
- blit_back  in  1  high-priority (bus hog) request
- stop_req  in  1  collision-stop request (used only with the optional feature)
- resume  in  1  resume pulse (used only with the optional feature)
- abort  in  1  abort pulse (used only with the optional feature)
- blit_breq  out  2  [0] normal bus request, [1] high-priority request
- bus_oe  out  1  enable for blit_addr/mreq/width/read drivers
- mreq_out  out  1  memory request
- blit_addr_out  out  ADDR_W  registered bus address
- width_out  out  4  registered transfer width
- read_out  out  1  1 = read phase, 0 = write phase
- phase  out  3  current phase index 0-5, to the address unit
- phase_adv  out  1  one-cycle pulse: address unit steps the current phase pointer
- busy  out  1  blit in progress
- stopped  out  1  halted on collision
- inner_rem  out  CNT_W  remaining phrases
- blit_int  out  1  one-cycle completion pulse

Behaviour:
- Reset (async, xreset_n low) forces state IDLE and clears all outputs and registers to 0, including mid-cycle; mreq drops immediately.
- States: IDLE, SETUP, CYC, STOPPED, DONE.
- IDLE: on cmd_go, latch phase_en and load inner_cnt into inner_rem.
  - If inner_cnt==0 or phase_en==0: go to DONE.
  - Otherwise: phase = lowest enabled bit, go to SETUP.
  - cmd_go is ignored in every other state.
- SETUP (1 cycle): capture address, phase_width, and read = (phase<4) into output registers; go to CYC.
- CYC: bus_oe=1 and mreq_out=1; address/width/read are held stable; blit_breq[0]=1.
  - Wait indefinitely for ack.
  - On the ack cycle: pulse phase_adv, then select the next enabled phase after the current one.
    - If one exists: load it into phase, go to SETUP.
    - Else (phrase complete): decrement inner_rem.
      - Result 0: go to DONE.
      - Otherwise: phase = lowest enabled bit, go to SETUP.
- blit_breq[1] = blit_breq[0] & blit_back. blit_breq is 0 outside CYC.
- Minimum throughput: 2 clocks per bus cycle.
- cmd_go→first mreq latency is 2 clocks: SETUP, then CYC.
- DONE (1 cycle): blit_int=1; busy falls in the following cycle; go to IDLE.
- busy=1 in SETUP, CYC, STOPPED, and DONE.
- inner_rem saturates at 0 and never wraps.

Optional Feature:
- Macro: BLIT_COLLISION_STOP_EN.
- With the macro defined:
  - stop_req high on the ack cycle of a dstdwrite or dstzwrite phase goes to STOPPED instead of advancing. phase_adv still pulses. blit_breq=0, mreq=0, stopped=1.
  - In STOPPED, resume continues with the normal next-phase/decrement logic.
  - In STOPPED, abort goes to DONE, with blit_int as usual.
  - abort has priority if resume and abort are both high.
- Without the macro: stop_req/resume/abort are ignored, stopped is tied 0, and STOPPED is unreachable.

Decomposition:
- Shared package blit_pkg holds:
  - phase index constants PH_SRCD..PH_DSTZW (0-5)
  - state enum
  - width code constants
- Natural sub-module: blit_phase_pick, a combinational next-enabled-phase priority picker returning index plus a wrap flag.

Test Plan:
- inner_cnt=3, phase_en=6'b010001, ack one cycle after each mreq → bus order R(0),W(4),R,W,R,W; 6 phase_adv pulses; blit_int 1 cycle; inner_rem 3→2→1→0.
- inner_cnt=0, phase_en=1 → no mreq, blit_int on the cycle after cmd_go; busy high for that one cycle.
- ack delayed 5 cycles, blit_back=1 → mreq/address/width stable all 5 cycles; blit_breq=2'b11; a cmd_go pulse mid-blit is ignored.
- xreset_n low during CYC → mreq_out, blit_breq, and busy drop without waiting for a clock; after release, IDLE accepts a new cmd_go.
- Macro on: phase_en=6'b010000, stop_req at the first write ack → stopped=1, breq=0; resume → second phrase runs; repeat with abort → blit_int, inner_rem unchanged.
- Macro off: same stimulus → stop_req ignored, blit completes normally.
